// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg: opcodes, format enum, NOP word and buffer-entry type shared by the encoder.
package rv32_enc_pkg;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_entry_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_OP:                     return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
            OP_STORE:                  return FMT_S;
            OP_BRANCH:                 return FMT_B;
            OP_LUI, OP_AUIPC:          return FMT_U;
            OP_JAL:                    return FMT_J;
            default:                   return FMT_ILL;
        endcase
    endfunction
endpackage

// File: rtl/rv32_instr_encoder_if.sv
// rv32_instr_encoder_if: decoded-field input handshake and encoded-word output handshake.
interface rv32_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/rv32_enc_fifo.sv
// rv32_enc_fifo: DEPTH-entry valid/ready FIFO; ready comes from the registered count, no bypass.
module rv32_enc_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign push_ready = cnt_q < (AW+1)'(DEPTH);
    assign pop_valid  = cnt_q != '0;
    assign pop_data   = pop_valid ? mem_q[rd_q] : '0;
    assign do_push    = push && push_ready;
    assign do_pop     = pop && pop_valid;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs decoded RV32I fields into an instruction word, NOP+err when unencodable.
// Optional RV32_ENC_STICKY_ERR_EN adds err_sticky, set by any accepted bad input until reset.
module rv32_instr_encoder
    import rv32_enc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32_instr_encoder_if.slave  bus,
    output logic [CNT_W-1:0]     enc_count
`ifdef RV32_ENC_STICKY_ERR_EN
    ,
    output logic                 err_sticky
`endif
);
    fmt_e             fmt;
    logic [31:0]      imm, word;
    logic             ok, accept;
    enc_entry_t       ent, head;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;

    assign imm    = bus.in_imm;
    assign fmt    = fmt_of(bus.in_opcode);
    assign accept = bus.in_valid && bus.in_ready;

    // Range checks: every immediate bit above the format's top bit must match the sign bit.
    always_comb begin
        word = NOP_INSTR;
        ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                ok   = 1'b1;
            end
            FMT_I: begin
                word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                ok   = (&imm[31:11]) || !(|imm[31:11]);
            end
            FMT_S: begin
                word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
                ok   = (&imm[31:11]) || !(|imm[31:11]);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
                ok   = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
            end
            FMT_U: begin
                word = {imm[31:12], bus.in_rd, bus.in_opcode};
                ok   = imm[11:0] == 12'd0;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
                ok   = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
            end
            default: begin
                word = NOP_INSTR;
                ok   = 1'b0;
            end
        endcase
        ent.instr = ok ? word : NOP_INSTR;
        ent.err   = !ok;
    end

    rv32_enc_fifo #(.DEPTH(DEPTH), .DATA_W($bits(enc_entry_t))) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (bus.in_valid),
        .push_data  (ent),
        .push_ready (bus.in_ready),
        .pop        (bus.out_ready),
        .pop_valid  (bus.out_valid),
        .pop_data   (head)
    );

    assign bus.out_instr = head.instr;
    assign bus.out_err   = head.err;
    assign enc_count_d   = (accept && !(&enc_count_q)) ? enc_count_q + CNT_W'(1) : enc_count_q;
    assign enc_count     = enc_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) enc_count_q <= '0;
        else        enc_count_q <= enc_count_d;
    end

`ifdef RV32_ENC_STICKY_ERR_EN
    logic err_sticky_q, err_sticky_d;

    assign err_sticky_d = err_sticky_q || (accept && ent.err);
    assign err_sticky   = err_sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sticky_q <= 1'b0;
        else        err_sticky_q <= err_sticky_d;
    end
`endif
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: directed plan vectors plus random traffic against a queue-based reference model.
module tb_rv32_instr_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32_instr_encoder_if bus();
    logic [CNT_W-1:0] enc_count;
`ifdef RV32_ENC_STICKY_ERR_EN
    logic err_sticky;
`endif

    rv32_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .enc_count (enc_count)
`ifdef RV32_ENC_STICKY_ERR_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [32:0] mq[$];
    int m_cnt = 0;
    logic m_sticky = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {err, instr}; legality judged as signed numeric ranges and alignment.
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
        int s;
        logic ok;
        logic [31:0] w;
        s = $signed(imm);
        ok = 1'b0;
        w = 32'h0;
        case (op)
            7'b0110011: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                ok = (s >= -2048) && (s <= 2047);
                w = {imm[11:0], rs1, f3, rd, op};
            end
            7'b0100011: begin
                ok = (s >= -2048) && (s <= 2047);
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            7'b1100011: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            7'b0110111, 7'b0010111: begin
                ok = (imm % 32'd4096) == 32'd0;
                w = {imm[31:12], rd, op};
            end
            7'b1101111: begin
                ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h00000013};
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, input logic rdy);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.out_ready = rdy;
    endtask

    task automatic step();
        bit fire_in, fire_out;
        logic [32:0] e;
        @(posedge clk);
        fire_in  = bus.in_valid && (mq.size() < DEPTH);
        fire_out = bus.out_ready && (mq.size() != 0);
        e = ref_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3, bus.in_funct7, bus.in_imm);
        if (fire_out) void'(mq.pop_front());
        if (fire_in) begin
            mq.push_back(e);
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_sticky = m_sticky | e[32];
        end
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_instr", bus.out_instr, mq[0][31:0]);
            check("out_err", 32'(bus.out_err), 32'(mq[0][32]));
        end else begin
            check("out_instr_empty", bus.out_instr, 32'h0);
            check("out_err_empty", 32'(bus.out_err), 32'h0);
        end
        check("enc_count", 32'(enc_count), 32'(m_cnt));
`ifdef RV32_ENC_STICKY_ERR_EN
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic single(input string tag, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
        drive(1'b1, op, rd, rs1, rs2, f3, 7'h0, imm, 1'b1);
        step();
        check(tag, bus.out_instr, exp_instr);
        check({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
        drive(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b1);
        step();
    endtask

    task automatic do_reset();
        drive(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0;
        m_sticky = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_enc_count", 32'(enc_count), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    endtask

    logic [31:0] bnd [12] = '{32'd2047, -32'd2048, 32'd2048, -32'd2049, 32'd4094, -32'd4096,
                              32'd4096, -32'd4098, 32'd1048574, -32'd1048576, 32'd1048576, 32'h12345000};
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000};

    initial begin
        drive(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_enc_count", 32'(enc_count), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step();

        single("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        check("addi_count", 32'(enc_count), 32'h1);
        single("sw", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, 32'h0020A423, 1'b0);
        single("beq", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        single("lui", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
        single("lui_bad", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345001, 32'h00000013, 1'b1);
        single("jal_odd", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'h00000013, 1'b1);
        single("ill_op", 7'b0000000, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 32'h00000013, 1'b1);
        single("addi_clean", 7'b0010011, 5'd2, 5'd3, 5'd0, 3'd0, 32'd5, 32'h00518113, 1'b0);
`ifdef RV32_ENC_STICKY_ERR_EN
        check("sticky_held", 32'(err_sticky), 32'h1);
`endif

        do_reset();
        drive(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 1'b0);
        step();
        drive(1'b1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2, 1'b0);
        step();
        check("bp_full_ready", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3, 1'b0);
        step();
        check("bp_held_count", 32'(enc_count), 32'h2);
        check("bp_head_a", bus.out_instr, 32'h00100093);
        bus.out_ready = 1'b1;
        step();
        check("bp_head_b", bus.out_instr, 32'h00200113);
        check("bp_c_not_yet", 32'(enc_count), 32'h2);
        step();
        check("bp_c_count", 32'(enc_count), 32'h3);
        check("bp_head_c", bus.out_instr, 32'h00300193);
        bus.in_valid = 1'b0;
        step();
        check("bp_drained", 32'(bus.out_valid), 32'h0);

        drive(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd7, 1'b0);
        step();
        step();
        do_reset();
        single("after_rst", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = {20'($urandom), 12'h0};
                3: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: imm = bnd[$urandom_range(0, 11)];
            endcase
            drive($urandom_range(0, 9) < 7, ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
                  5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm,
                  $urandom_range(0, 9) < 6);
            step();
        end
        check("saturated", 32'(enc_count), 32'((1 << CNT_W) - 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
